// File: rtl/memory_multiport_if.sv
// Handshake bundle for memory_multiport: one write channel (address + data join), R read channels.
// MEMORY_MASK_EN adds the byte strobe that travels with the write data.
interface memory_multiport_if #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 256,
    parameter int unsigned R = 2
);
    localparam int unsigned AW = $clog2(D);

    logic [AW-1:0]   s_wa_data;
    logic            s_wa_valid;
    logic            s_wa_ready;
    logic [W-1:0]    s_wd_data;
    logic            s_wd_valid;
    logic            s_wd_ready;
`ifdef MEMORY_MASK_EN
    logic [W/8-1:0]  s_wd_strb;
`endif
    logic [R*AW-1:0] s_ra_data;
    logic [R-1:0]    s_ra_valid;
    logic [R-1:0]    s_ra_ready;
    logic [R*W-1:0]  m_rd_data;
    logic [R-1:0]    m_rd_valid;
    logic [R-1:0]    m_rd_ready;

`ifdef MEMORY_MASK_EN
    modport master (
        output s_wa_data, s_wa_valid, input s_wa_ready,
        output s_wd_data, s_wd_valid, s_wd_strb, input s_wd_ready,
        output s_ra_data, s_ra_valid, input s_ra_ready,
        input m_rd_data, m_rd_valid, output m_rd_ready
    );
    modport slave (
        input s_wa_data, s_wa_valid, output s_wa_ready,
        input s_wd_data, s_wd_valid, s_wd_strb, output s_wd_ready,
        input s_ra_data, s_ra_valid, output s_ra_ready,
        output m_rd_data, m_rd_valid, input m_rd_ready
    );
`else
    modport master (
        output s_wa_data, s_wa_valid, input s_wa_ready,
        output s_wd_data, s_wd_valid, input s_wd_ready,
        output s_ra_data, s_ra_valid, input s_ra_ready,
        input m_rd_data, m_rd_valid, output m_rd_ready
    );
    modport slave (
        input s_wa_data, s_wa_valid, output s_wa_ready,
        input s_wd_data, s_wd_valid, output s_wd_ready,
        input s_ra_data, s_ra_valid, output s_ra_ready,
        output m_rd_data, m_rd_valid, input m_rd_ready
    );
`endif
endinterface

// File: rtl/memory_multiport.sv
// Register-file memory, one joined write channel and R single-stage read pipelines, zero-filled
// by an INIT sweep after every reset. Optional byte-masked writes under MEMORY_MASK_EN.
module memory_multiport #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 256,
    parameter int unsigned R = 2
) (
    input  logic                clk,
    input  logic                rst,
    memory_multiport_if.slave   bus
);
    localparam int unsigned AW = $clog2(D);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q;
    logic [AW-1:0]     init_cnt_q;
    logic              run;
    logic              wr_en;
    logic [W-1:0]      wr_word;
    logic [W-1:0]      mem_q [D];
    logic [R-1:0]      ra_ready;
    logic [R-1:0]      rd_valid_q;
    logic [R-1:0][W-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + AW'(1);
                    if (init_cnt_q == AW'(D - 1)) state_q <= StRun;
                end
                StRun: state_q <= StRun;
            endcase
        end
    end

    assign run   = (state_q == StRun);
    assign wr_en = run & bus.s_wa_valid & bus.s_wd_valid;

`ifdef MEMORY_MASK_EN
    always_comb begin
        wr_word = mem_q[bus.s_wa_data];
        for (int unsigned b = 0; b < W / 8; b++) begin
            if (bus.s_wd_strb[b]) wr_word[b*8 +: 8] = bus.s_wd_data[b*8 +: 8];
        end
    end
`else
    assign wr_word = bus.s_wd_data;
`endif

    // Storage carries no reset; the INIT sweep provides the zero fill.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[init_cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[bus.s_wa_data] <= wr_word;
        end
    end

    always_comb begin
        ra_ready = '0;
        for (int unsigned r = 0; r < R; r++) begin
            ra_ready[r] = run & (~rd_valid_q[r] | bus.m_rd_ready[r]);
        end
    end

    // Reads sample mem_q before this edge's write lands, giving read-first ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            for (int unsigned r = 0; r < R; r++) begin
                if (ra_ready[r] && bus.s_ra_valid[r]) begin
                    rd_data_q[r]  <= mem_q[bus.s_ra_data[r*AW +: AW]];
                    rd_valid_q[r] <= 1'b1;
                end else if (bus.m_rd_ready[r]) begin
                    rd_valid_q[r] <= 1'b0;
                end
            end
        end
    end

    assign bus.s_wa_ready = wr_en;
    assign bus.s_wd_ready = wr_en;
    assign bus.s_ra_ready = ra_ready;
    assign bus.m_rd_valid = rd_valid_q;
    assign bus.m_rd_data  = rd_data_q;
endmodule

// File: tb/tb_memory_multiport.sv
// Self-checking bench for memory_multiport: directed steps plus random traffic against an
// array-based reference memory with per-channel expected read registers.
module tb_memory_multiport;
    localparam int unsigned W  = 16;
    localparam int unsigned D  = 256;
    localparam int unsigned R  = 2;
    localparam int unsigned AW = $clog2(D);

    logic clk;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    memory_multiport_if #(.W(W), .D(D), .R(R)) bus ();

    memory_multiport #(.W(W), .D(D), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] ref_mem [D];
    logic [R-1:0] ref_valid;
    logic [W-1:0] ref_data [R];
    int           init_left;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < int'(D); i++) ref_mem[i] = '0;
        for (int r = 0; r < int'(R); r++) ref_data[r] = '0;
        ref_valid = '0;
        init_left = D;
    endtask

    task automatic idle();
        bus.s_wa_valid = 1'b0;
        bus.s_wd_valid = 1'b0;
        bus.s_ra_valid = '0;
        bus.m_rd_ready = '1;
    endtask

    task automatic set_wr(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.s_wa_valid = v;
        bus.s_wd_valid = v;
        bus.s_wa_data  = a;
        bus.s_wd_data  = d;
    endtask

    task automatic set_rd(input int r, input logic v, input logic [AW-1:0] a);
        bus.s_ra_valid[r]          = v;
        bus.s_ra_data[r*AW +: AW]  = a;
    endtask

    // One clock: check readies against the rules, advance the model, check read outputs.
    task automatic cycle();
        logic           run;
        logic           w_exp;
        logic [R-1:0]   ra_exp;
        logic [R-1:0]   nv;
        logic [W-1:0]   nd [R];
        logic [W-1:0]   word;
        logic [AW-1:0]  a;
        #1;
        run   = (init_left == 0);
        w_exp = run && bus.s_wa_valid && bus.s_wd_valid;
        for (int r = 0; r < int'(R); r++) ra_exp[r] = run && (!ref_valid[r] || bus.m_rd_ready[r]);
        check("wa_ready", 64'(bus.s_wa_ready), 64'(w_exp));
        check("wd_ready", 64'(bus.s_wd_ready), 64'(w_exp));
        check("ra_ready", 64'(bus.s_ra_ready), 64'(ra_exp));
        for (int r = 0; r < int'(R); r++) begin
            nv[r] = ref_valid[r];
            nd[r] = ref_data[r];
            if (ra_exp[r] && bus.s_ra_valid[r]) begin
                a     = bus.s_ra_data[r*AW +: AW];
                nd[r] = ref_mem[a];
                nv[r] = 1'b1;
            end else if (bus.m_rd_ready[r]) begin
                nv[r] = 1'b0;
            end
        end
        if (w_exp) begin
            word = ref_mem[bus.s_wa_data];
`ifdef MEMORY_MASK_EN
            for (int b = 0; b < int'(W / 8); b++)
                if (bus.s_wd_strb[b]) word[b*8 +: 8] = bus.s_wd_data[b*8 +: 8];
`else
            word = bus.s_wd_data;
`endif
            ref_mem[bus.s_wa_data] = word;
        end
        if (!run) init_left--;
        @(posedge clk);
        @(negedge clk);
        ref_valid = nv;
        for (int r = 0; r < int'(R); r++) ref_data[r] = nd[r];
        check("rd_valid", 64'(bus.m_rd_valid), 64'(ref_valid));
        for (int r = 0; r < int'(R); r++)
            if (ref_valid[r])
                check($sformatf("rd_data%0d", r), 64'(bus.m_rd_data[r*W +: W]), 64'(ref_data[r]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, 64'(bus.m_rd_valid), 64'(0));
        check({tag, "_rd_data"},  64'(bus.m_rd_data),  64'(0));
        check({tag, "_ra_ready"}, 64'(bus.s_ra_ready), 64'(0));
        check({tag, "_wa_ready"}, 64'(bus.s_wa_ready), 64'(0));
    endtask

    initial begin
        rst = 1'b0;
        idle();
        set_wr(1'b1, '0, '0);
        bus.s_ra_data = '0;
        bus.s_ra_valid = '1;
`ifdef MEMORY_MASK_EN
        bus.s_wd_strb = '1;
`endif
        ref_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // INIT sweep with both reads and a write requested: nothing may be accepted.
        for (int i = 0; i < int'(D); i++) begin
            set_rd(0, 1'b1, AW'($urandom));
            set_rd(1, 1'b1, AW'($urandom));
            cycle();
        end

        // Every word reads zero after INIT.
        idle();
        for (int i = 0; i < int'(D); i++) begin
            set_rd(0, 1'b1, AW'(i));
            set_rd(1, 1'b1, AW'(D - 1 - i));
            cycle();
        end
        idle();
        cycle();

        // Fill with random data while random read traffic runs alongside.
        for (int i = 0; i < int'(D); i++) begin
            set_wr(1'b1, AW'(i), W'($urandom));
            set_rd(0, 1'($urandom), AW'($urandom));
            set_rd(1, 1'($urandom), AW'($urandom));
            bus.m_rd_ready = R'($urandom);
            cycle();
        end
        idle();
        cycle();
        for (int i = 0; i < int'(D); i++) begin
            set_rd(0, 1'b1, AW'(i));
            set_rd(1, 1'b1, AW'(D - 1 - i));
            cycle();
        end
        idle();
        cycle();

        // Read-first on a same-edge collision, then the new word on the next edge.
        set_wr(1'b1, AW'(8'h10), W'(16'h0000));
        cycle();
        set_wr(1'b1, AW'(8'h10), W'(16'h1234));
        set_rd(0, 1'b1, AW'(8'h10));
        cycle();
        check("rd_first_old", 64'(bus.m_rd_data[W-1:0]), 64'(16'h0000));
        set_wr(1'b0, '0, '0);
        cycle();
        check("rd_after_new", 64'(bus.m_rd_data[W-1:0]), 64'(16'h1234));
        idle();
        cycle();

        // Channel 1 stalled for 5 cycles while channel 0 streams.
        bus.m_rd_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            set_rd(0, 1'b1, AW'(i + 40));
            set_rd(1, 1'b1, AW'(i + 100));
            cycle();
        end
        check("stall_ra_ready1", 64'(bus.s_ra_ready[1]), 64'(0));
        check("stall_rd_data1", 64'(bus.m_rd_data[W +: W]), 64'(ref_mem[100]));
        idle();
        cycle();

        // Lone write-address valid must wait; the join completes once data arrives.
        bus.s_wa_valid = 1'b1;
        bus.s_wa_data  = AW'(8'h30);
        bus.s_wd_data  = W'(16'hBEEF);
        for (int i = 0; i < 10; i++) cycle();
        bus.s_wd_valid = 1'b1;
        cycle();
        set_wr(1'b0, '0, '0);
        set_rd(0, 1'b1, AW'(8'h30));
        set_rd(1, 1'b1, AW'(8'h30));
        cycle();
        check("join_rd0", 64'(bus.m_rd_data[W-1:0]), 64'(16'hBEEF));
        check("join_rd1", 64'(bus.m_rd_data[W +: W]), 64'(16'hBEEF));

        // Top address.
        idle();
        set_wr(1'b1, AW'(D - 1), W'(16'hC0DE));
        cycle();
        set_wr(1'b0, '0, '0);
        set_rd(0, 1'b1, AW'(D - 1));
        set_rd(1, 1'b1, AW'(D - 1));
        cycle();
        check("top_addr", 64'(bus.m_rd_data[W-1:0]), 64'(16'hC0DE));

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            bus.s_wa_valid = 1'($urandom);
            bus.s_wd_valid = 1'($urandom);
            bus.s_wa_data  = AW'($urandom);
            bus.s_wd_data  = W'($urandom);
`ifdef MEMORY_MASK_EN
            bus.s_wd_strb  = (W/8)'($urandom);
`endif
            set_rd(0, 1'($urandom), AW'($urandom));
            set_rd(1, 1'($urandom), AW'($urandom));
            bus.m_rd_ready = R'($urandom);
            cycle();
        end
        idle();
        cycle();

`ifdef MEMORY_MASK_EN
        bus.s_wd_strb = 2'b11;
        set_wr(1'b1, AW'(8'h20), W'(16'hAAAA));
        cycle();
        bus.s_wd_strb = 2'b01;
        set_wr(1'b1, AW'(8'h20), W'(16'h5555));
        cycle();
        bus.s_wd_strb = 2'b00;
        set_wr(1'b1, AW'(8'h20), W'(16'hFFFF));
        cycle();
        set_wr(1'b0, '0, '0);
        set_rd(0, 1'b1, AW'(8'h20));
        cycle();
        check("mask_rd", 64'(bus.m_rd_data[W-1:0]), 64'(16'hAA55));
        bus.s_wd_strb = '1;
`else
        set_wr(1'b1, AW'(8'h20), W'(16'hAA55));
        cycle();
        set_wr(1'b0, '0, '0);
        set_rd(0, 1'b1, AW'(8'h20));
        cycle();
        check("full_rd", 64'(bus.m_rd_data[W-1:0]), 64'(16'hAA55));
`endif

        // Reset mid-stream: outputs clear at once, contents re-zeroed.
        idle();
        set_rd(0, 1'b1, AW'(8'h20));
        set_rd(1, 1'b1, AW'(8'h10));
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        ref_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        for (int i = 0; i < int'(D); i++) cycle();
        set_rd(0, 1'b1, AW'(8'h20));
        set_rd(1, 1'b1, AW'(8'h10));
        cycle();
        check("reread_20", 64'(bus.m_rd_data[W-1:0]), 64'(0));
        check("reread_10", 64'(bus.m_rd_data[W +: W]), 64'(0));
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
